fetch_queue_unit: RTL and testbench
===================================

// Module: fetch_queue_unit
// PURPOSE
// Instruction-fetch front end for the pipelined successor of the single-cycle CPU. Owns the PC
// and issues requests to a synchronous instruction ROM with 1-cycle read latency. Buffers
// fetched {pc, instr} pairs in a DEPTH-entry queue, which a valid/ready handshake drains into decode.
// Handles branch/jump redirects and the ILLOP/XADR exception vectors with queue flush.
// PARAMETERS
// DEPTH     4             queue entries; legal range 2..16, and any value >= 2 gives one instr/cycle
// RESET_PC  32'h80000000  PC fetched first after reset
// ILLOP     32'h80000004  illegal-op / interrupt vector
// XADR      32'h80000008  exception-address vector
// PORTS
// clk          in   1   clock, rising edge
// reset        in   1   asynchronous, active-high
// imem_req     out  1   ROM read request this cycle
// imem_addr    out  32  ROM address; valid when imem_req=1
// imem_rdata   in   32  ROM data, valid the cycle after the request
// redir_valid  in   1   redirect fetch this cycle
// redir_sel    in   2   00 redir_target, 01 ILLOP, 10 XADR, 11 redir_target
// redir_target in   32  branch/jump/jr target
// out_valid    out  1   queue head valid
// out_ready    in   1   decode accepts head
// out_pc       out  32  PC of head instruction
// out_instr    out  32  head instruction
// out_count    out  5   current queue occupancy, 0..DEPTH
// BEHAVIOUR
// - Reset (async): fetch_pc=RESET_PC; queue empty; inflight=0; out_valid=0; out_pc=0;
//   out_instr=0; out_count=0. imem_req=0 while reset is high.
// - PC increment preserves the supervisor bit: next = {pc[31], pc[30:0]+31'd4}, so the
//   low 31 bits wrap and bit 31 is never toggled by sequential fetch.
// - pop = out_valid & out_ready. inflight is 1 when a request issued last cycle still owes data.
// - Issue: imem_req = !reset & !redir_valid & (out_count + inflight - pop < DEPTH).
//   imem_addr = fetch_pc, and fetch_pc advances at the edge when imem_req=1.
// - Response: in the cycle after an issue, imem_rdata is pushed at the edge with the issued PC,
//   unless a redirect occurred in that cycle. At most 1 request is in flight.
// - Queue: circular buffer. Push and pop in the same cycle leave the count unchanged. There is
//   no fall-through, so an entry is visible the cycle after its push. out_pc/out_instr
//   show the head, and hold their last value when out_valid=0.
// - Redirect (redir_valid sampled at edge n):
//   - A pop in cycle n still completes.
//   - All queue entries and the in-flight response are discarded, and out_count=0 after edge n.
//   - fetch_pc <= selected vector, and no request is issued in cycle n.
//   - After edge n the request goes out with imem_addr=vector.
//   - out_valid=1 with out_pc=vector from edge n+2 onward: redirect-to-use latency is 2 cycles.
//   - Back-to-back redirects: the last one wins, and each one kills the previous request.
// - Full queue: no issue while occupancy plus in-flight would exceed DEPTH. There is no
//   overflow, and no response is ever dropped except by a redirect.
// - Empty queue: out_valid=0, and out_ready is ignored.
// - Reset asserted mid-stream: immediate return to the reset state. The ROM response that
//   arrives after reset deasserts is ignored, because inflight=0.
// - Steady state with out_ready=1 delivers 1 instr/cycle with consecutive PCs.
// TESTING
// T1 Reset release, ready=1: out_pc sequence is 0x80000000, 0x80000004, 0x80000008... with
//    no bubbles after the first out_valid, 2 cycles after the first imem_req.
// T2 Backpressure, DEPTH=4: ready=0 for 10 cycles gives out_count=4 and imem_req=0. Then
//    ready=1 drains 4 entries in order, and fetch resumes with no gaps or duplicates.
// T3 Redirect: with 3 entries queued and 1 in flight, redir_sel=00, target=0x00400020.
//    out_count=0 next cycle, the stale ROM data is not queued, and out_pc=0x00400020 at n+2.
// T4 Vectors: redir_sel=01 gives out_pc=0x80000004 first; redir_sel=10 gives 0x80000008.
//    Redirects on 2 consecutive cycles (00 then 01) yield only the ILLOP stream.
// T5 Wrap: redirect to 0xFFFFFFFC gives a next PC of 0x80000000. Redirect to 0x7FFFFFFC
//    gives a next PC of 0x00000000.
// T6 Reset pulse mid-stream while an entry is in flight: all outputs return to reset
//    values, and the restart fetches 0x80000000 first.

Source files
------------

// File: rtl/fetch_queue_unit.sv
// rtl/fetch_queue_unit.sv - instruction fetch front end: PC, ROM request, {pc,instr} queue, redirects
module fetch_queue_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h80000000,
    parameter logic [31:0] ILLOP    = 32'h80000004,
    parameter logic [31:0] XADR     = 32'h80000008
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redir_valid,
    input  logic [1:0]  redir_sel,
    input  logic [31:0] redir_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic [4:0]  out_count
);
    localparam int            PW     = $clog2(DEPTH);
    localparam logic [5:0]    DEPTH6 = 6'(DEPTH);
    localparam logic [PW-1:0] LAST   = PW'(DEPTH - 1);

    logic [31:0]   fetch_pc, infl_pc, vector;
    logic          inflight, pop, push;
    logic [31:0]   q_pc    [DEPTH];
    logic [31:0]   q_instr [DEPTH];
    logic [PW-1:0] head, tail, head_nxt;
    logic [4:0]    count, count_nxt;
    logic [5:0]    occ;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    assign out_valid = (count != 5'd0);
    assign out_count = count;
    assign pop       = out_valid & out_ready;
    // A response owed by last cycle's request is discarded if a redirect lands now.
    assign push      = inflight & ~redir_valid;
    assign occ       = {1'b0, count} + {5'd0, inflight} - {5'd0, pop};
    assign imem_req  = ~reset & ~redir_valid & (occ < DEPTH6);
    assign imem_addr = fetch_pc;

    always_comb begin
        vector    = redir_target;
        head_nxt  = pop ? ptr_inc(head) : head;
        count_nxt = count + {4'd0, push} - {4'd0, pop};
        case (redir_sel)
            2'b01:   vector = ILLOP;
            2'b10:   vector = XADR;
            default: vector = redir_target;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc  <= RESET_PC;
            infl_pc   <= '0;
            inflight  <= 1'b0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            out_pc    <= '0;
            out_instr <= '0;
        end else if (redir_valid) begin
            fetch_pc <= vector;
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                infl_pc  <= fetch_pc;
                fetch_pc <= {fetch_pc[31], fetch_pc[30:0] + 31'd4};
            end
            if (push) begin
                tail <= ptr_inc(tail);
            end
            head  <= head_nxt;
            count <= count_nxt;
            // Registered head view; the new head may be the entry being pushed this edge.
            if (count_nxt != 5'd0) begin
                if (push && head_nxt == tail) begin
                    out_pc    <= infl_pc;
                    out_instr <= imem_rdata;
                end else begin
                    out_pc    <= q_pc[head_nxt];
                    out_instr <= q_instr[head_nxt];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[tail]    <= infl_pc;
            q_instr[tail] <= imem_rdata;
        end
    end
endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb/tb_fetch_queue_unit.sv - randomized and directed bench for fetch_queue_unit with queue reference model
module tb_fetch_queue_unit;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h80000000;
    localparam logic [31:0] ILLOP    = 32'h80000004;
    localparam logic [31:0] XADR     = 32'h80000008;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        redir_valid = 1'b0;
    logic [1:0]  redir_sel = 2'b00;
    logic [31:0] redir_target = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc, out_instr;
    logic [4:0]  out_count;

    int nvec = 0;
    int nerr = 0;

    logic [31:0] mq_pc[$];
    logic [31:0] mq_instr[$];
    logic [31:0] m_pc, m_infl_pc, m_hold_pc, m_hold_instr;
    logic        m_infl;
    logic        exp_req, exp_valid;
    int          exp_cnt;
    logic [31:0] exp_pc, exp_instr;

    fetch_queue_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .ILLOP(ILLOP), .XADR(XADR)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redir_valid(redir_valid), .redir_sel(redir_sel),
        .redir_target(redir_target), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .out_count(out_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h5A3C96E1;
    endfunction

    always @(posedge clk) if (imem_req) imem_rdata <= rom(imem_addr);

    function automatic logic [31:0] pc_inc(input logic [31:0] p);
        return (p & 32'h80000000) | ((p + 32'd4) & 32'h7FFFFFFF);
    endfunction

    task automatic model_reset();
        mq_pc.delete();
        mq_instr.delete();
        m_pc = RESET_PC;
        m_infl = 1'b0;
        m_infl_pc = '0;
        m_hold_pc = '0;
        m_hold_instr = '0;
    endtask

    function automatic void predict();
        int sz;
        sz = mq_pc.size();
        exp_valid = (sz > 0);
        exp_cnt   = sz;
        exp_pc    = (sz > 0) ? mq_pc[0] : m_hold_pc;
        exp_instr = (sz > 0) ? mq_instr[0] : m_hold_instr;
        exp_req   = !reset && !redir_valid && (sz + int'(m_infl) - int'(exp_valid && out_ready) < DEPTH);
    endfunction

    task automatic step();
        logic mpop, mreq, rv;
        logic [31:0] vec;
        predict();
        mpop = exp_valid && out_ready;
        mreq = exp_req;
        rv   = redir_valid;
        vec  = (redir_sel == 2'b01) ? ILLOP : (redir_sel == 2'b10) ? XADR : redir_target;
        @(posedge clk);
        if (mpop) begin
            void'(mq_pc.pop_front());
            void'(mq_instr.pop_front());
        end
        if (rv) begin
            mq_pc.delete();
            mq_instr.delete();
            m_infl = 1'b0;
            m_pc = vec;
        end else begin
            if (m_infl) begin
                mq_pc.push_back(m_infl_pc);
                mq_instr.push_back(rom(m_infl_pc));
            end
            m_infl = mreq;
            if (mreq) begin
                m_infl_pc = m_pc;
                m_pc = pc_inc(m_pc);
            end
        end
        if (mq_pc.size() > 0) begin
            m_hold_pc = mq_pc[0];
            m_hold_instr = mq_instr[0];
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        redir_valid = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        nvec++;
        if (imem_req !== 1'b0 || out_valid !== 1'b0 || out_count !== 5'd0 || out_pc !== 32'd0 || out_instr !== 32'd0) begin
            nerr++;
            $display("FAIL reset: req=%b vld=%b cnt=%0d pc=%h ins=%h, want all zero", imem_req, out_valid, out_count, out_pc, out_instr);
        end
        reset = 1'b0;
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        #1;
        nvec++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            nerr++;
            $display("FAIL stream_first_req: req=%b addr=%h, want 1 %h", imem_req, imem_addr, RESET_PC);
        end
        step();
        #1;
        nvec++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC + 32'd4 || out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL stream_second: req=%b addr=%h vld=%b, want 1 %h 0", imem_req, imem_addr, out_valid, RESET_PC + 32'd4);
        end
        step();
        for (int k = 0; k < 10; k++) begin
            #1;
            nvec++;
            if (out_valid !== 1'b1 || out_pc !== RESET_PC + 32'(4 * k) || out_instr !== rom(RESET_PC + 32'(4 * k))) begin
                nerr++;
                $display("FAIL stream_seq %0d: vld=%b pc=%h ins=%h, want 1 %h %h", k, out_valid, out_pc, out_instr,
                         RESET_PC + 32'(4 * k), rom(RESET_PC + 32'(4 * k)));
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] base;
        out_ready = 1'b0;
        repeat (10) step();
        #1;
        nvec++;
        if (out_count !== 5'd4 || imem_req !== 1'b0 || out_valid !== 1'b1) begin
            nerr++;
            $display("FAIL backpressure_full: cnt=%0d req=%b vld=%b, want 4 0 1", out_count, imem_req, out_valid);
        end
        base = mq_pc[0];
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            predict();
            nvec++;
            if (out_valid !== 1'b1 || out_pc !== base + 32'(4 * k) || out_pc !== exp_pc || out_count !== 5'(exp_cnt)) begin
                nerr++;
                $display("FAIL backpressure_drain %0d: vld=%b pc=%h cnt=%0d, want 1 %h %0d", k, out_valid, out_pc, out_count,
                         base + 32'(4 * k), exp_cnt);
            end
            step();
        end
    endtask

    task automatic test_redirect();
        do_reset();
        out_ready = 1'b0;
        repeat (4) step();
        #1;
        nvec++;
        if (out_count !== 5'd3 || imem_req !== 1'b0 || m_infl !== 1'b1) begin
            nerr++;
            $display("FAIL redirect_setup: cnt=%0d req=%b, want 3 0", out_count, imem_req);
        end
        redir_valid = 1'b1;
        redir_sel = 2'b00;
        redir_target = 32'h00400020;
        step();
        redir_valid = 1'b0;
        #1;
        nvec++;
        if (out_count !== 5'd0 || out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h00400020) begin
            nerr++;
            $display("FAIL redirect_flush: cnt=%0d vld=%b req=%b addr=%h, want 0 0 1 00400020", out_count, out_valid, imem_req, imem_addr);
        end
        step();
        #1;
        nvec++;
        if (out_count !== 5'd0 || out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL redirect_stale: cnt=%0d vld=%b, want 0 0", out_count, out_valid);
        end
        step();
        #1;
        nvec++;
        if (out_valid !== 1'b1 || out_pc !== 32'h00400020 || out_instr !== rom(32'h00400020) || out_count !== 5'd1) begin
            nerr++;
            $display("FAIL redirect_use: vld=%b pc=%h ins=%h cnt=%0d, want 1 00400020 %h 1", out_valid, out_pc, out_instr, out_count,
                     rom(32'h00400020));
        end
    endtask

    task automatic test_vectors();
        logic [1:0]  sels[3]  = '{2'b01, 2'b10, 2'b11};
        logic [31:0] wants[3] = '{ILLOP, XADR, 32'h00001230};
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            repeat (3) step();
            redir_valid = 1'b1;
            redir_sel = sels[c];
            redir_target = 32'h00001230;
            step();
            redir_valid = 1'b0;
            repeat (2) step();
            #1;
            nvec++;
            if (out_valid !== 1'b1 || out_pc !== wants[c]) begin
                nerr++;
                $display("FAIL vector sel=%b: vld=%b pc=%h, want 1 %h", sels[c], out_valid, out_pc, wants[c]);
            end
        end
        redir_valid = 1'b1;
        redir_sel = 2'b00;
        redir_target = 32'h00400100;
        step();
        redir_sel = 2'b01;
        step();
        redir_valid = 1'b0;
        #1;
        nvec++;
        if (imem_addr !== ILLOP || imem_req !== 1'b1) begin
            nerr++;
            $display("FAIL vector_b2b_req: req=%b addr=%h, want 1 %h", imem_req, imem_addr, ILLOP);
        end
        repeat (2) step();
        for (int k = 0; k < 3; k++) begin
            #1;
            nvec++;
            if (out_valid !== 1'b1 || out_pc !== ILLOP + 32'(4 * k)) begin
                nerr++;
                $display("FAIL vector_b2b_stream %0d: vld=%b pc=%h, want 1 %h", k, out_valid, out_pc, ILLOP + 32'(4 * k));
            end
            step();
        end
    endtask

    task automatic test_wrap();
        logic [31:0] tgt[2]  = '{32'hFFFFFFFC, 32'h7FFFFFFC};
        logic [31:0] nxt[2]  = '{32'h80000000, 32'h00000000};
        out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            redir_valid = 1'b1;
            redir_sel = 2'b00;
            redir_target = tgt[c];
            step();
            redir_valid = 1'b0;
            #1;
            nvec++;
            if (imem_req !== 1'b1 || imem_addr !== tgt[c]) begin
                nerr++;
                $display("FAIL wrap_target %0d: req=%b addr=%h, want 1 %h", c, imem_req, imem_addr, tgt[c]);
            end
            step();
            #1;
            nvec++;
            if (imem_req !== 1'b1 || imem_addr !== nxt[c]) begin
                nerr++;
                $display("FAIL wrap_next %0d: req=%b addr=%h, want 1 %h", c, imem_req, imem_addr, nxt[c]);
            end
            repeat (3) step();
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        repeat (5) step();
        reset = 1'b1;
        #1;
        nvec++;
        if (imem_req !== 1'b0 || out_valid !== 1'b0 || out_count !== 5'd0 || out_pc !== 32'd0 || out_instr !== 32'd0) begin
            nerr++;
            $display("FAIL reset_mid: req=%b vld=%b cnt=%0d pc=%h ins=%h, want all zero", imem_req, out_valid, out_count, out_pc, out_instr);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        nvec++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            nerr++;
            $display("FAIL reset_restart_req: req=%b addr=%h, want 1 %h", imem_req, imem_addr, RESET_PC);
        end
        repeat (2) step();
        #1;
        nvec++;
        if (out_valid !== 1'b1 || out_pc !== RESET_PC || out_instr !== rom(RESET_PC)) begin
            nerr++;
            $display("FAIL reset_restart_use: vld=%b pc=%h ins=%h, want 1 %h %h", out_valid, out_pc, out_instr, RESET_PC, rom(RESET_PC));
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            out_ready = ($urandom_range(0, 9) < 6);
            redir_valid = ($urandom_range(0, 19) == 0);
            redir_sel = 2'($urandom_range(0, 3));
            redir_target = {$urandom} & 32'hFFFFFFFC;
            #1;
            predict();
            nvec++;
            if (imem_req !== exp_req || (exp_req && imem_addr !== m_pc) || out_valid !== exp_valid ||
                out_count !== 5'(exp_cnt) || out_pc !== exp_pc || out_instr !== exp_instr) begin
                nerr++;
                $display("FAIL random %0d: got req=%b addr=%h vld=%b cnt=%0d pc=%h ins=%h want req=%b addr=%h vld=%b cnt=%0d pc=%h ins=%h",
                         i, imem_req, imem_addr, out_valid, out_count, out_pc, out_instr,
                         exp_req, m_pc, exp_valid, exp_cnt, exp_pc, exp_instr);
            end
            step();
        end
        redir_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_vectors();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
